// File: rtl/gp_seq_chunk_adder.sv
// Sequential wide adder/subtractor: resolves one WIDTH-bit chunk per cycle from a
// group generate/propagate prefix and carries the chunk carry-out to the next cycle.
module gp_seq_chunk_adder #(
  parameter int WIDTH  = 4,
  parameter int NCHUNK = 8,
  localparam int W     = WIDTH * NCHUNK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] ch_p, ch_g, ch_s;
  logic [WIDTH:0]   pre_g, pre_p, ch_c;

  // Chunk datapath: prefix G/P over bits below i gives the carry into bit i.
  always_comb begin
    ch_p     = a_q[int'(idx_q)*WIDTH +: WIDTH] ^ b_q[int'(idx_q)*WIDTH +: WIDTH];
    ch_g     = a_q[int'(idx_q)*WIDTH +: WIDTH] & b_q[int'(idx_q)*WIDTH +: WIDTH];
    pre_g    = '0;
    pre_p    = '0;
    ch_c     = '0;
    ch_s     = '0;
    pre_p[0] = 1'b1;
    ch_c[0]  = carry_q;
    for (int i = 1; i <= WIDTH; i++) begin
      pre_g[i] = ch_g[i-1] | (ch_p[i-1] & pre_g[i-1]);
      pre_p[i] = ch_p[i-1] & pre_p[i-1];
      ch_c[i]  = pre_g[i] | (pre_p[i] & carry_q);
    end
    for (int j = 0; j < WIDTH; j++) begin
      ch_s[j] = ch_p[j] ^ ch_c[j];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        sum_d[int'(idx_q)*WIDTH +: WIDTH] = ch_s;
        carry_d = ch_c[WIDTH];
        if (idx_q == LAST_IDX) begin
          cout_d  = ch_c[WIDTH];
          ovf_d   = ch_c[WIDTH-1] ^ ch_c[WIDTH];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand latches only matter after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_gp_seq_chunk_adder.sv
// Randomized and directed bench for gp_seq_chunk_adder against a plain-arithmetic model.
module tb_gp_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid, out_ready;
  logic [31:0] sum;
  logic        cout, ovf;

  int n_cmp = 0;
  int n_err = 0;

  gp_seq_chunk_adder #(.WIDTH(4), .NCHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from ordinary modulo-2^32 arithmetic
  function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    logic [31:0] bb;
    logic [32:0] full;
    logic        o;
    bb   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + 33'(sb ? 1'b1 : ci);
    o    = (av[31] == bb[31]) && (full[31] != av[31]);
    return {o, full[32], full[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait (bounded) for its result; result left un-consumed.
  task automatic start_and_wait(input logic [31:0] av, input logic [31:0] bv,
                                input logic ci, input logic sb, input string tag);
    int cyc;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic directed(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic sb, input logic [31:0] es, input logic ec,
                          input logic eo, input string tag);
    start_and_wait(av, bv, ci, sb, tag);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    consume(tag);
  endtask

  logic [31:0] hs;
  logic        hc, ho;
  logic [33:0] e;
  logic [33:0] expq[$];
  int          got_n, cyc_n, last_res;
  bit          accepted;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    directed(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "ff_plus1");
    directed(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, "max_pos");
    directed(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_5_7");
    directed(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, "sub_cin_ign");
    directed(32'h0000000F, 32'h1, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, "chunk01");
    directed(32'hFFFFFFF0, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, "ripple_all");
    directed(32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, "neg_ovf");

    // result held under backpressure; in_valid pulses ignored
    start_and_wait(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, "hold");
    e = model(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0);
    chk("hold_sum0", sum, e[31:0]);
    hs = sum; hc = cout; ho = ovf;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = $urandom; b = $urandom; sub = 1'b0;
      step();
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_sum", sum, hs);
      chk("hold_cout", 32'(cout), 32'(hc));
      chk("hold_ovf", 32'(ovf), 32'(ho));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume("hold");
    chk("hold_idle_ready", 32'(in_ready), 32'd1);
    chk("hold_idle_sum", sum, hs);
    step();
    chk("hold_no_accept", 32'(in_ready), 32'd1);

    // abort mid-operation with reset once idx has reached 3
    a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", sum, 32'd0);
    directed(32'd2, 32'd3, 1'b0, 1'b0, 32'd5, 1'b0, 1'b0, "after_abort");

    // back-to-back random stream with a model queue
    out_ready = 1'b1; in_valid = 1'b1;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    got_n = 0; cyc_n = 0; last_res = -1;
    while (got_n < 100 && cyc_n < 1200) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("b2b_unexpected", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("b2b_sum", sum, e[31:0]);
          chk("b2b_cout", 32'(cout), 32'(e[32]));
          chk("b2b_ovf", 32'(ovf), 32'(e[33]));
        end
        if (last_res >= 0) chk("b2b_spacing", 32'(cyc_n - last_res), 32'd10);
        last_res = cyc_n;
        got_n++;
      end
      accepted = in_ready;
      if (accepted) expq.push_back(model(a, b, cin, sub));
      step();
      cyc_n++;
      if (accepted) begin
        case ($urandom_range(0, 3))
          0: begin a = 32'hFFFFFFFF; b = $urandom_range(0, 2); end
          1: begin a = 32'h7FFFFFFF; b = $urandom; end
          default: begin a = $urandom; b = $urandom; end
        endcase
        cin = 1'($urandom); sub = 1'($urandom);
      end
    end
    chk("b2b_count", 32'(got_n), 32'd100);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
